// File: rtl/countdown_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_sequencer
// Description : Control FSM plus 4-digit packed-BCD countdown register for a
//               seven-segment countdown display. Owns the step prescaler,
//               start/pause/load control and expiry detection.
//               Optional build macro: MMSS_MODE_EN (digit 1 counts 5..0 so the
//               value reads as MM:SS; load clamps digit 1 to 5).
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_sequencer #(
  parameter int          TICK_DIV    = 100000000,
  parameter logic [15:0] RESET_VALUE = 16'h9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        load,
  input  logic [15:0] preset_bcd,
  output logic [15:0] bcd_value,
  output logic        running,
  output logic        expired,
  output logic        tick
);

  // Prescaler width; TICK_DIV >= 2 keeps this at least one bit.
  localparam int              c_PW   = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0] c_TERM = c_PW'(TICK_DIV - 1);
  localparam logic [c_PW-1:0] c_ONE  = c_PW'(1);

  // Largest legal value of digit 1 (tens position of the low byte).
`ifdef MMSS_MODE_EN
  localparam logic [3:0] c_D1_MAX = 4'd5;
`else
  localparam logic [3:0] c_D1_MAX = 4'd9;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW-1:0]   r_presc;
  logic [c_PW-1:0]   w_presc_nxt;
  logic [15:0]       r_bcd;
  logic [15:0]       w_bcd_nxt;
  logic              w_tick_nxt;
  logic              r_running;
  logic              r_expired;
  logic              r_tick;

  logic              w_term;
  logic [15:0]       w_bcd_dec;
  logic [15:0]       w_preset_clamped;

  // Clamp every nibble to its digit maximum so a bad preset can never put a
  // non-BCD code into the count register.
  function automatic logic [15:0] f_clamp(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  lim;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      lim = (d == 1) ? c_D1_MAX : 4'd9;
      r[d*4 +: 4] = (v[d*4 +: 4] > lim) ? lim : v[d*4 +: 4];
    end
    return r;
  endfunction

  // Decrement by one with a per-digit borrow chain. A zero input stays zero
  // so the count can never wrap below 0000.
  function automatic logic [15:0] f_bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = (v != 16'h0000);
    for (int d = 0; d < 4; d++) begin
      if (borrow) begin
        if (r[d*4 +: 4] == 4'd0) begin
          r[d*4 +: 4] = (d == 1) ? c_D1_MAX : 4'd9;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_term           = (r_state == ST_RUN) && (r_presc == c_TERM);
  assign w_bcd_dec        = f_bcd_dec(r_bcd);
  assign w_preset_clamped = f_clamp(preset_bcd);

  // Next-state, prescaler and count logic; priority is load, then the
  // terminal tick, then start_stop.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_bcd_nxt   = r_bcd;
    w_tick_nxt  = 1'b0;

    if (load) begin
      // A start_stop in the same cycle is intentionally dropped.
      w_bcd_nxt   = w_preset_clamped;
      w_presc_nxt = '0;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_presc_nxt = '0;
          if (start_stop && (r_bcd != 16'h0000)) begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_term) begin
            w_presc_nxt = '0;
            w_bcd_nxt   = w_bcd_dec;
            w_tick_nxt  = 1'b1;
            // Reaching zero wins over a coincident pause request.
            if (w_bcd_dec == 16'h0000) begin
              w_state_nxt = ST_EXPIRED;
            end else if (start_stop) begin
              w_state_nxt = ST_PAUSE;
            end
          end else begin
            w_presc_nxt = r_presc + c_ONE;
            if (start_stop) begin
              w_state_nxt = ST_PAUSE;
            end
          end
        end

        ST_PAUSE: begin
          // Prescaler is held so a resume continues the partial step.
          if (start_stop) begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_EXPIRED: begin
          w_bcd_nxt = 16'h0000;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_bcd     <= RESET_VALUE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_bcd     <= w_bcd_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= (w_state_nxt == ST_EXPIRED);
      r_tick    <= w_tick_nxt;
    end
  end

  assign bcd_value = r_bcd;
  assign running   = r_running;
  assign expired   = r_expired;
  assign tick      = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_countdown_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_sequencer
// Description : Table-driven self-checking bench for countdown_sequencer
//               (TICK_DIV = 4) with a queue of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_sequencer;

  localparam int c_TICK_DIV = 4;

`ifdef MMSS_MODE_EN
  localparam logic [15:0] V_0999 = 16'h0959;
  localparam logic [15:0] V_0099 = 16'h0059;
  localparam logic [15:0] V_0098 = 16'h0058;
  localparam logic [15:0] V_0199 = 16'h0159;
`else
  localparam logic [15:0] V_0999 = 16'h0999;
  localparam logic [15:0] V_0099 = 16'h0099;
  localparam logic [15:0] V_0098 = 16'h0098;
  localparam logic [15:0] V_0199 = 16'h0199;
`endif

  logic        clock;
  logic        reset;
  logic        start_stop;
  logic        load;
  logic [15:0] preset_bcd;
  logic [15:0] bcd_value;
  logic        running;
  logic        expired;
  logic        tick;

  int n_tests;
  int n_fail;

  countdown_sequencer #(
    .TICK_DIV    (c_TICK_DIV),
    .RESET_VALUE (16'h9999)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .load       (load),
    .preset_bcd (preset_bcd),
    .bcd_value  (bcd_value),
    .running    (running),
    .expired    (expired),
    .tick       (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ss;
    logic        ld;
    logic [15:0] pre;
    int          waitn;
    logic [15:0] e_bcd;
    logic        e_run;
    logic        e_exp;
    logic        e_tick;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] bcd;
    logic        run;
    logic        exp;
    logic        tck;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic rst, input logic ss, input logic ld,
                              input logic [15:0] pre, input int waitn,
                              input logic [15:0] e_bcd, input logic e_run,
                              input logic e_exp, input logic e_tick);
    vec_t v;
    v.rst = rst; v.ss = ss; v.ld = ld; v.pre = pre; v.waitn = waitn;
    v.e_bcd = e_bcd; v.e_run = e_run; v.e_exp = e_exp; v.e_tick = e_tick;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %h required %h", idx, nm, act, req);
    end
  endtask

  // One clock cycle with the given inputs; inputs change on the falling edge
  // and are released 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic ss, input logic ld,
                     input logic [15:0] pre);
    @(negedge clock);
    reset = rst; start_stop = ss; load = ld; preset_bcd = pre;
    @(posedge clock);
    #1;
    reset = 1'b0; start_stop = 1'b0; load = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   k;
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start_stop = 1'b0;
    load       = 1'b0;
    preset_bcd = 16'h0000;

    //                rst  ss  ld  preset   wait  bcd      run  exp  tick
    // Reset held two cycles, then start and first step.
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h9999, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2, 16'h9999, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h9998, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h9998, 1, 0, 0));
    // Borrow chain and load clamping.
    tbl.push_back(mk(0, 0, 1, 16'h1000, 0, 16'h1000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h1000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 3, V_0999,   1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h00AF, 0, V_0099,   0, 0, 0));
    // Pause after two cycles, frozen for ten, resume finishes the step.
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, V_0099,   1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, V_0099,   1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, V_0099,   0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 9, V_0099,   0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, V_0099,   1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, V_0099,   1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, V_0098,   1, 0, 1));
    // Expiry and recovery by load.
    tbl.push_back(mk(0, 0, 1, 16'h0002, 0, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0002, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 3, 16'h0001, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 3, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0005, 0, 16'h0005, 0, 0, 0));
    // Load with start_stop: start dropped, stays idle.
    tbl.push_back(mk(0, 1, 1, 16'h0042, 0, 16'h0042, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2, 16'h0042, 0, 0, 0));
    // start_stop on the terminal tick from 0003: decrement and pause.
    tbl.push_back(mk(0, 0, 1, 16'h0003, 0, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0003, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2, 16'h0003, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0002, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 5, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0002, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 3, 16'h0001, 1, 0, 1));
    // Start at zero is ignored.
    tbl.push_back(mk(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 4, 16'h0000, 0, 0, 0));
    // Hundreds borrow into digit 1 and digit-1 load clamp.
    tbl.push_back(mk(0, 0, 1, 16'h0100, 0, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 3, V_0099,   1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0199, 0, V_0199,   0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      e.idx = i; e.bcd = tbl[i].e_bcd; e.run = tbl[i].e_run;
      e.exp = tbl[i].e_exp; e.tck = tbl[i].e_tick;
      exp_q.push_back(e);
      cyc(tbl[i].rst, tbl[i].ss, tbl[i].ld, tbl[i].pre);
      for (int w = 0; w < tbl[i].waitn; w++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      e = exp_q.pop_front();
      chk("bcd_value", e.idx, bcd_value, e.bcd);
      chk("running",   e.idx, {15'd0, running}, {15'd0, e.run});
      chk("expired",   e.idx, {15'd0, expired}, {15'd0, e.exp});
      chk("tick",      e.idx, {15'd0, tick},    {15'd0, e.tck});
    end

    // Latency: first tick must arrive exactly TICK_DIV cycles after start.
    cyc(1'b0, 1'b0, 1'b1, 16'h0002);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      if (tick) begin k = c; break; end
    end
    chk("first_tick_latency", 100, 16'(k), 16'(c_TICK_DIV));
    chk("first_tick_value",   100, bcd_value, 16'h0001);

    // Expiry must follow one full step later, bounded wait.
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      if (expired) begin k = c; break; end
    end
    chk("expiry_latency", 101, 16'(k), 16'(c_TICK_DIV));
    chk("expiry_tick",    101, {15'd0, tick}, 16'd1);
    chk("expiry_value",   101, bcd_value, 16'h0000);

    // Load must win over a terminal tick in the same cycle.
    cyc(1'b0, 1'b0, 1'b1, 16'h0007);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int c = 0; c < c_TICK_DIV - 1; c++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0030);
    chk("load_over_tick_bcd",  102, bcd_value, 16'h0030);
    chk("load_over_tick_tick", 102, {15'd0, tick}, 16'd0);
    chk("load_over_tick_run",  102, {15'd0, running}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
